// File: rtl/divider_ctrl_if.sv
// Request/response bundle for the iterative divider.
// The master drives requests; the divider sits on the slave side.
interface divider_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op_div;
  logic             op_divu;
  logic             op_rem;
  logic             op_remu;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             ready;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op_div, op_divu, op_rem, op_remu, dividend, divisor, flush,
    input  ready, busy, result_valid, result
  );

  modport slave (
    input  start, op_div, op_divu, op_rem, op_remu, dividend, divisor, flush,
    output ready, busy, result_valid, result
  );
endinterface

// File: rtl/divider_ctrl.sv
// Radix-2 restoring divider, one quotient bit per cycle (DIV/DIVU/REM/REMU).
// Optional DIVIDER_CTRL_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC.
module divider_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  divider_ctrl_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [1:0] {OP_DIV, OP_DIVU, OP_REM, OP_REMU} op_e;

  state_e           state, state_nxt;
  op_e              op_q, op_sel;
  logic             op_any, accept, early;
  logic [WIDTH-1:0] a_q, b_q, bmag, quo, rem, quo_nxt, rem_nxt, result_q;
  logic [WIDTH:0]   r_sh, diff;
  logic [CNT_W-1:0] step;

  function automatic logic is_signed(input op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic [WIDTH-1:0] mag(input op_e op, input logic [WIDTH-1:0] x);
    return (is_signed(op) && x[WIDTH-1]) ? -x : x;
  endfunction

  // Sign fix-up plus the two corner cases, applied to the raw magnitudes.
  function automatic logic [WIDTH-1:0] finish(input op_e op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] q,
                                              input logic [WIDTH-1:0] r);
    logic rem_op;
    rem_op = (op == OP_REM) || (op == OP_REMU);
    if (b == '0)
      return rem_op ? a : '1;
    if (is_signed(op) && a == MIN_NEG && b == '1)
      return rem_op ? '0 : a;
    if (rem_op)
      return (is_signed(op) && a[WIDTH-1]) ? -r : r;
    return (is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1])) ? -q : q;
  endfunction

  always_comb begin
    op_sel = OP_DIV;
    op_any = 1'b1;
    if      (bus.op_div)  op_sel = OP_DIV;
    else if (bus.op_divu) op_sel = OP_DIVU;
    else if (bus.op_rem)  op_sel = OP_REM;
    else if (bus.op_remu) op_sel = OP_REMU;
    else                  op_any = 1'b0;
  end

  assign accept = bus.start && (state == IDLE) && !bus.flush && op_any;

`ifdef DIVIDER_CTRL_EARLY_OUT_EN
  assign early = (bus.divisor == '0) ||
                 (is_signed(op_sel) && bus.dividend == MIN_NEG && bus.divisor == '1);
`else
  assign early = 1'b0;
`endif

  // Partial remainder is always < divisor, so one extra bit catches the borrow.
  always_comb begin
    r_sh = {rem, quo[WIDTH-1]};
    diff = r_sh - {1'b0, bmag};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = (quo << 1) | WIDTH'(1);
    end else begin
      rem_nxt = r_sh[WIDTH-1:0];
      quo_nxt = quo << 1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_nxt = early ? DONE : CALC;
        CALC:    if (step == LAST_STEP) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      result_q <= '0;
      op_q     <= OP_DIV;
      a_q      <= '0;
      b_q      <= '0;
      bmag     <= '0;
      quo      <= '0;
      rem      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= op_sel;
        a_q  <= bus.dividend;
        b_q  <= bus.divisor;
        quo  <= mag(op_sel, bus.dividend);
        bmag <= mag(op_sel, bus.divisor);
        rem  <= '0;
        step <= '0;
        if (early)
          result_q <= finish(op_sel, bus.dividend, bus.divisor, {WIDTH{1'b0}}, {WIDTH{1'b0}});
      end else if (state == CALC && !bus.flush) begin
        quo  <= quo_nxt;
        rem  <= rem_nxt;
        step <= step + 1'b1;
        if (step == LAST_STEP)
          result_q <= finish(op_q, a_q, b_q, quo_nxt, rem_nxt);
      end
    end
  end

  assign bus.ready        = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = (state == DONE);
  assign bus.result       = result_q;
endmodule

// File: tb/tb_divider_ctrl.sv
// Randomized bench for divider_ctrl against an arithmetic reference model.
// Honors DIVIDER_CTRL_EARLY_OUT_EN for expected latency.
module tb_divider_ctrl;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic clk, rst;
  int   n_chk, n_pass;
  logic [W-1:0] last_exp;

  divider_ctrl_if #(.WIDTH(W)) bus ();
  divider_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ops mask = {remu, rem, divu, div}; lowest set bit wins
  function automatic int pick_op(input logic [3:0] ops);
    for (int i = 0; i < 4; i++) if (ops[i]) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 0) return (op >= 2) ? a : '1;
    case (op)
      0:       return W'(sa / sb);
      1:       return a / b;
      2:       return W'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int exp_latency(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIVIDER_CTRL_EARLY_OUT_EN
    if (b == 0 || ((op == 0 || op == 2) && a == MIN_NEG && b == '1)) return 1;
`endif
    return W + 1;
  endfunction

  task automatic idle_inputs();
    bus.start = 0; bus.flush = 0;
    {bus.op_remu, bus.op_rem, bus.op_divu, bus.op_div} = 4'b0;
  endtask

  // Drive at negedge; accept happens on the following posedge.
  task automatic run_op(input logic [3:0] ops, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke);
    int op, lat;
    bit bad;
    logic [W-1:0] exp;
    op  = pick_op(ops);
    exp = model(op, a, b);
    bus.start = 1;
    {bus.op_remu, bus.op_rem, bus.op_divu, bus.op_div} = ops;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    idle_inputs();
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    lat = 1;
    bad = 0;
    while (!bus.result_valid && lat < 100) begin
      if (bus.ready || !bus.busy) bad = 1;
      bus.start   = poke && (lat == 5);
      bus.op_divu = poke && (lat == 5);
      @(negedge clk);
      lat++;
    end
    idle_inputs();
    if (bus.ready || !bus.busy) bad = 1;
    chk("latency", 64'(lat), 64'(exp_latency(op, a, b)));
    chk("result", 64'(bus.result), 64'(exp));
    chk("busy_hold", 64'(bad), 64'd0);
    @(negedge clk);
    chk("done_1cyc", 64'({bus.result_valid, bus.ready, bus.busy}), 64'(3'b010));
    last_exp = exp;
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.result_valid) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; last_exp = '0;
    idle_inputs();
    bus.dividend = '0; bus.divisor = '0;
    rst = 1;
    bus.start = 1; bus.op_div = 1; bus.flush = 1;
    repeat (3) @(negedge clk);
    chk("rst_state", 64'({bus.ready, bus.busy, bus.result_valid}), 64'(3'b100));
    chk("rst_result", 64'(bus.result), 64'd0);
    idle_inputs();
    rst = 0;
    @(negedge clk);

    run_op(4'b0001, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(4'b0100, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h10, 0);
    run_op(4'b1000, 32'hFFFF_FFFF, 32'h10, 0);
    run_op(4'b0001, -32'd100, 32'd0, 0);
    run_op(4'b0100, -32'd100, 32'd0, 0);
    run_op(4'b0010, 32'h1234_5678, 32'd0, 0);
    run_op(4'b1000, 32'h1234_5678, 32'd0, 0);
    run_op(4'b0001, MIN_NEG, 32'hFFFF_FFFF, 0);
    run_op(4'b0100, MIN_NEG, 32'hFFFF_FFFF, 0);
    run_op(4'b0001, 32'd1000, 32'hFFFF_FFF9, 1);
    run_op(4'b1110, 32'hF000_0000, 32'd7, 0);
    run_op(4'b1100, 32'hF000_0003, 32'd7, 0);

    // start with no op select is ignored
    bus.start = 1;
    @(negedge clk);
    idle_inputs();
    chk("noop_start", 64'({bus.ready, bus.busy}), 64'(2'b10));

    // flush wins over start in IDLE
    bus.start = 1; bus.op_div = 1; bus.flush = 1;
    bus.dividend = 32'd9; bus.divisor = 32'd3;
    @(negedge clk);
    idle_inputs();
    chk("start_flush", 64'({bus.ready, bus.busy}), 64'(2'b10));
    watch_no_valid("start_flush_nv", 3);

    // flush mid-CALC
    bus.start = 1; bus.op_divu = 1;
    bus.dividend = 32'd12345; bus.divisor = 32'd11;
    @(negedge clk);
    idle_inputs();
    repeat (10) @(negedge clk);
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    chk("flush_idle", 64'({bus.ready, bus.busy, bus.result_valid}), 64'(3'b100));
    chk("flush_result", 64'(bus.result), 64'(last_exp));
    watch_no_valid("flush_nv", 40);
    chk("flush_result2", 64'(bus.result), 64'(last_exp));

    for (int i = 0; i < 40; i++) begin
      logic [3:0] ops;
      logic [W-1:0] a, b;
      int sel;
      ops = 4'b0001 << $urandom_range(0, 3);
      a = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = '0;
        1:       begin a = MIN_NEG; b = '1; end
        2:       b = $urandom_range(1, 15);
        3:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      run_op(ops, a, b, $urandom_range(0, 3) == 0);
    end

    // reset aborts CALC
    bus.start = 1; bus.op_rem = 1;
    bus.dividend = 32'd777; bus.divisor = 32'd5;
    @(negedge clk);
    idle_inputs();
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_state", 64'({bus.ready, bus.busy, bus.result_valid}), 64'(3'b100));
    chk("rst_mid_result", 64'(bus.result), 64'd0);
    watch_no_valid("rst_mid_nv", 40);

    run_op(4'b0001, 32'd100, 32'd7, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
